// File: rtl/imem_loader_pkg.sv
// Shared sizing constants and FSM state type for the streaming
// instruction-memory loader and its byte packer.
package imem_loader_pkg;

  localparam int XLEN             = 32;
  localparam int IMEM_AWIDTH      = 10;
  localparam int CNT_WIDTH        = 16;
  localparam int LOADER_HDR_BYTES = CNT_WIDTH / 8;
  localparam int BYTE_LANES       = XLEN / 8;
  localparam int IMEM_WORDS       = (2 ** IMEM_AWIDTH) / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an accepted byte stream little-endian into XLEN-bit words; the
// completed word and its valid pulse are presented in the cycle of the last byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [7:0]      i_byte,
  output logic            o_word_valid,
  output logic [XLEN-1:0] o_word
);

  localparam int                LANE_W    = $clog2(BYTE_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTE_LANES - 1);
  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

  logic [LANE_W-1:0] r_lane;
  logic [XLEN-9:0]   r_acc;

  // Lane counter and lower-lane accumulator; the top lane is never stored.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_lane <= '0;
      r_acc  <= '0;
    end else if (i_en) begin
      r_lane <= r_lane + LANE_ONE;
      for (int k = 0; k < BYTE_LANES - 1; k++) begin
        if (r_lane == LANE_W'(k)) begin
          r_acc[8*k +: 8] <= i_byte;
        end
      end
    end
  end

  assign o_word_valid = i_en && (r_lane == LAST_LANE);
  assign o_word       = {i_byte, r_acc};

endmodule

// File: rtl/imem_loader.sv
// Streaming program loader: header word count, then little-endian payload
// words written sequentially into instruction memory while the core is held in reset.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_in_valid,
  input  logic [7:0]             i_in_data,
  output logic                   o_in_ready,
  output logic                   o_imem_wen,
  output logic [IMEM_AWIDTH-1:0] o_imem_waddr,
  output logic [XLEN-1:0]        o_imem_wdata,
  output logic                   o_core_rst_n,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow
);

  localparam int                   HDR_IDX_W = $clog2(LOADER_HDR_BYTES + 1);
  localparam logic [HDR_IDX_W-1:0] HDR_LAST  = HDR_IDX_W'(LOADER_HDR_BYTES - 1);
  localparam logic [HDR_IDX_W-1:0] HDR_ONE   = HDR_IDX_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CAP_WORDS = CNT_WIDTH'(IMEM_WORDS);

  loader_state_t          r_state;
  loader_state_t          w_state_nxt;
  logic [HDR_IDX_W-1:0]   r_hdr_idx;
  logic [CNT_WIDTH-1:0]   r_word_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_full;
  logic [CNT_WIDTH-1:0]   r_word_idx;
  logic                   r_drain;
  logic                   r_in_ready;
  logic                   r_imem_wen;
  logic [IMEM_AWIDTH-1:0] r_imem_waddr;
  logic [XLEN-1:0]        r_imem_wdata;
  logic                   r_core_rst_n;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;
  logic                   w_accept;
  logic                   w_start_ok;
  logic                   w_hdr_last;
  logic                   w_pk_en;
  logic                   w_word_valid;
  logic [XLEN-1:0]        w_word;
  logic                   w_in_cap;
  logic                   w_last_word;
  logic                   w_in_ready_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_core_rst_n_nxt;

  assign w_accept    = i_in_valid && r_in_ready;
  assign w_start_ok  = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_hdr_last  = (r_state == HDR) && w_accept && (r_hdr_idx == HDR_LAST);
  assign w_pk_en     = (r_state == LOAD) && w_accept;
  assign w_in_cap    = (r_word_idx < CAP_WORDS);
  assign w_last_word = w_word_valid && ((r_word_idx + CNT_ONE) == r_word_cnt);

  imem_loader_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (w_start_ok),
    .i_en         (w_pk_en),
    .i_byte       (i_in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Header count including the byte on the bus, so the zero-length check needs no extra cycle.
  always_comb begin
    w_cnt_full = r_word_cnt;
    for (int k = 0; k < LOADER_HDR_BYTES; k++) begin
      if (r_hdr_idx == HDR_IDX_W'(k)) begin
        w_cnt_full[8*k +: 8] = i_in_data;
      end else begin
        w_cnt_full[8*k +: 8] = r_word_cnt[8*k +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; LOAD lingers one write-slot cycle after the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = HDR;
        else            w_state_nxt = IDLE;
      end
      HDR: begin
        if (w_hdr_last) begin
          if (w_cnt_full == '0) w_state_nxt = DONE;
          else                  w_state_nxt = LOAD;
        end else begin
          w_state_nxt = HDR;
        end
      end
      LOAD: begin
        if (r_drain) w_state_nxt = DONE;
        else         w_state_nxt = LOAD;
      end
      DONE: begin
        if (w_start_ok) w_state_nxt = HDR;
        else            w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    w_busy_nxt       = (w_state_nxt == HDR) || (w_state_nxt == LOAD);
    w_in_ready_nxt   = (w_state_nxt == HDR) || ((w_state_nxt == LOAD) && !w_last_word);
    w_done_nxt       = (w_state_nxt == DONE);
    w_core_rst_n_nxt = (w_state_nxt == DONE);
  end

  // Registered status outputs and the memory write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_drain      <= 1'b0;
      r_imem_wen   <= 1'b0;
      r_imem_waddr <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_in_ready   <= w_in_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_drain      <= w_last_word;
      r_imem_wen   <= w_word_valid && w_in_cap;
      if (w_word_valid && w_in_cap) begin
        r_imem_waddr <= {r_word_idx[IMEM_AWIDTH-3:0], 2'b00};
        r_imem_wdata <= w_word;
      end
    end
  end

  // Session counters: header assembly, word index and sticky capacity overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hdr_idx  <= '0;
      r_word_cnt <= '0;
      r_word_idx <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_hdr_idx  <= '0;
      r_word_cnt <= '0;
      r_word_idx <= '0;
      r_overflow <= 1'b0;
    end else begin
      if ((r_state == HDR) && w_accept) begin
        r_word_cnt <= w_cnt_full;
        r_hdr_idx  <= r_hdr_idx + HDR_ONE;
      end
      if (w_word_valid) begin
        r_word_idx <= r_word_idx + CNT_ONE;
        if (!w_in_cap) r_overflow <= 1'b1;
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_imem_wen   = r_imem_wen;
  assign o_imem_waddr = r_imem_waddr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_core_rst_n = r_core_rst_n;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-count model of the load protocol
// checked every cycle, plus hand-computed expectations for each directed scenario.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_wen;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_imem_wen   (imem_wen),
    .o_imem_waddr (imem_waddr),
    .o_imem_wdata (imem_wdata),
    .o_core_rst_n (core_rst_n),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol model: tracks bytes consumed in the session and derives every output from that count.
  logic        m_ready = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_core = 1'b0;
  logic        m_ovf = 1'b0, m_pend = 1'b0, m_wen = 1'b0;
  logic [9:0]  m_waddr = 10'd0;
  logic [31:0] m_wdata = 32'd0, m_acc = 32'd0;
  int          m_nbytes = 0, m_cnt = 0;
  bit          chk_en = 1'b0;

  task automatic model_step();
    logic busy_pre, hs;
    int p, w;
    busy_pre = m_busy;
    hs       = in_valid && m_ready;
    m_wen    = 1'b0;
    if (rst) begin
      m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_core = 1'b0;
      m_ovf = 1'b0; m_pend = 1'b0; m_nbytes = 0; m_cnt = 0;
    end else begin
      if (m_pend) begin
        m_pend = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_core = 1'b1;
      end
      if (start && !busy_pre) begin
        m_busy = 1'b1; m_done = 1'b0; m_core = 1'b0; m_ovf = 1'b0;
        m_nbytes = 0; m_cnt = 0;
      end
      if (hs) begin
        if (m_nbytes < 2) begin
          m_cnt = m_cnt + (int'(in_data) << (8 * m_nbytes));
          m_nbytes++;
          if (m_nbytes == 2 && m_cnt == 0) begin
            m_busy = 1'b0; m_done = 1'b1; m_core = 1'b1;
          end
        end else begin
          p = m_nbytes - 2;
          m_acc[8*(p%4) +: 8] = in_data;
          m_nbytes++;
          if (p % 4 == 3) begin
            w = p / 4;
            if (w < 256) begin
              m_wen = 1'b1; m_waddr = 10'(w * 4); m_wdata = m_acc;
            end else begin
              m_ovf = 1'b1;
            end
            if (w == m_cnt - 1) m_pend = 1'b1;
          end
        end
      end
      m_ready = m_busy && !m_pend && ((m_nbytes < 2) || (m_nbytes < 2 + 4 * m_cnt));
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("core_rst_n", {31'd0, core_rst_n}, {31'd0, m_core});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("imem_wen", {31'd0, imem_wen}, {31'd0, m_wen});
      if (m_wen) begin
        chk("imem_waddr", {22'd0, imem_waddr}, {22'd0, m_waddr});
        chk("imem_wdata", imem_wdata, m_wdata);
      end
    end
  end

  logic [9:0]  wr_a[$];
  logic [31:0] wr_d[$];
  always @(negedge clk) begin
    if (imem_wen === 1'b1) begin
      wr_a.push_back(imem_waddr);
      wr_d.push_back(imem_wdata);
    end
  end

  logic [7:0] stream_q[$];

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    bit acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      in_valid = 1'b1;
      in_data  = b;
      start    = with_start && (t == 0);
      acc      = (in_ready === 1'b1);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL byte_accept: byte 0x%0h not accepted within 40 cycles, expected acceptance", b);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_q(input int gap, input int start_at);
    for (int i = 0; i < stream_q.size(); i++) send_byte(stream_q[i], gap, i == start_at);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_basic_writes(input string tag);
    chk({tag, " nwrites"}, 32'(wr_a.size()), 32'd2);
    if (wr_a.size() >= 2) begin
      chk({tag, " addr0"}, {22'd0, wr_a[0]}, 32'h0000_0000);
      chk({tag, " data0"}, wr_d[0], 32'h00a0_0513);
      chk({tag, " addr1"}, {22'd0, wr_a[1]}, 32'h0000_0004);
      chk({tag, " data1"}, wr_d[1], 32'h0010_0593);
    end
    chk({tag, " core_rst_n"}, {31'd0, core_rst_n}, 32'd1);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Reset held for three cycles.
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst imem_waddr", {22'd0, imem_waddr}, 32'd0);
    chk("rst imem_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle in_ready", {31'd0, in_ready}, 32'd0);

    // Basic back-to-back load.
    wr_a.delete(); wr_d.delete();
    pulse_start();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_q(0, -1);
    wait_done();
    repeat (3) @(negedge clk);
    check_basic_writes("basic");

    // Throttled source: valid every third cycle.
    wr_a.delete(); wr_d.delete();
    pulse_start();
    send_q(2, -1);
    wait_done();
    repeat (3) @(negedge clk);
    check_basic_writes("throttled");

    // Empty program.
    wr_a.delete(); wr_d.delete();
    pulse_start();
    stream_q = '{8'h00, 8'h00};
    send_q(0, -1);
    chk("empty done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    chk("empty nwrites", 32'(wr_a.size()), 32'd0);
    chk("empty core_rst_n", {31'd0, core_rst_n}, 32'd1);

    // Overflow: 257 words into a 256-word memory.
    wr_a.delete(); wr_d.delete();
    pulse_start();
    stream_q = '{8'h01, 8'h01};
    for (int i = 0; i < 1028; i++) stream_q.push_back(8'(i));
    send_q(0, -1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("ovf nwrites", 32'(wr_a.size()), 32'd256);
    if (wr_a.size() == 256) begin
      chk("ovf first data", wr_d[0], 32'h0302_0100);
      chk("ovf last addr", {22'd0, wr_a[255]}, 32'h0000_03fc);
      chk("ovf last data", wr_d[255], 32'hfffe_fdfc);
    end
    chk("ovf overflow", {31'd0, overflow}, 32'd1);
    chk("ovf done", {31'd0, done}, 32'd1);

    // Reset after five payload bytes, then reload with an ignored mid-load start.
    wr_a.delete(); wr_d.delete();
    pulse_start();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93};
    send_q(0, -1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("midrst waddr", {22'd0, imem_waddr}, 32'd0);
    chk("midrst wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wr_a.delete(); wr_d.delete();
    pulse_start();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_q(0, 5);
    wait_done();
    repeat (3) @(negedge clk);
    check_basic_writes("reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
